microinstruction_issue: RTL and testbench

//   Head of the microinstruction pipeline: the issuing end of the C/T field chain that the

---
 rtl/microinstruction_issue.sv | 117 +++++++++++
 tb/tb_microinstruction_issue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/microinstruction_issue.sv
// Issue head of the microinstruction C/T chain: accepts macro-ops, expands repeat bursts.
// Optional issue counter enabled by defining MICRO_ISSUE_STATS_EN.
module microinstruction_issue #(
    parameter int unsigned C_W    = 6,
    parameter int unsigned T_W    = 7,
    parameter int unsigned REP_W  = 4,
    parameter int unsigned T_STEP = 1
`ifdef MICRO_ISSUE_STATS_EN
    ,
    parameter int unsigned STAT_W = 16
`endif
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [C_W-1:0]   in_ctrl,
    input  logic [T_W-1:0]   in_target,
    input  logic [REP_W-1:0] in_repeat,
    input  logic             stall,
    output logic [C_W-1:0]   C1,
    output logic [T_W-1:0]   T1,
    output logic             issue_valid,
    output logic             last,
    output logic             busy
`ifdef MICRO_ISSUE_STATS_EN
    ,
    output logic [STAT_W-1:0] issue_count
`endif
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    localparam logic [T_W-1:0] L_STEP = T_W'(T_STEP);

    state_t           r_state;
    logic [REP_W-1:0] r_remaining;
    logic [C_W-1:0]   r_c1;
    logic [T_W-1:0]   r_t1;
    logic             r_issue_valid;
    logic             r_last;
    logic             w_accept;
    logic             w_load;

    assign in_ready    = (r_state == S_IDLE) && !stall;
    assign w_accept    = in_ready && in_valid;
    // A word lands in C1/T1 on an accept or on any unstalled burst-continuation edge.
    assign w_load      = w_accept || ((r_state == S_ISSUE) && !stall);

    assign C1          = r_c1;
    assign T1          = r_t1;
    assign issue_valid = r_issue_valid;
    assign last        = r_last;
    assign busy        = (r_state == S_ISSUE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_remaining   <= '0;
            r_c1          <= '0;
            r_t1          <= '0;
            r_issue_valid <= 1'b0;
            r_last        <= 1'b0;
        end else if (!stall) begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_c1          <= in_ctrl;
                        r_t1          <= in_target;
                        r_issue_valid <= 1'b1;
                        if (in_repeat == '0) begin
                            r_last <= 1'b1;
                        end else begin
                            r_last      <= 1'b0;
                            r_remaining <= in_repeat;
                            r_state     <= S_ISSUE;
                        end
                    end else begin
                        r_c1          <= '0;
                        r_issue_valid <= 1'b0;
                        r_last        <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_t1          <= r_t1 + L_STEP;
                    r_issue_valid <= 1'b1;
                    r_remaining   <= r_remaining - 1'b1;
                    if (r_remaining == REP_W'(1)) begin
                        r_last  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_last <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MICRO_ISSUE_STATS_EN
    logic [STAT_W-1:0] r_issue_count;

    assign issue_count = r_issue_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_issue_count <= '0;
        end else if (w_load && (r_issue_count != '1)) begin
            r_issue_count <= r_issue_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_microinstruction_issue.sv
// Self-checking bench for microinstruction_issue: directed scenarios plus random traffic
// against a word-queue reference model. Define MICRO_ISSUE_STATS_EN to also check issue_count.
module tb_microinstruction_issue;

    localparam int unsigned C_W    = 6;
    localparam int unsigned T_W    = 7;
    localparam int unsigned REP_W  = 4;
    localparam int unsigned T_STEP = 1;
    localparam int unsigned STAT_W = 4;

    logic             clock     = 1'b0;
    logic             reset_n   = 1'b0;
    logic             in_valid  = 1'b0;
    logic             stall     = 1'b0;
    logic [C_W-1:0]   in_ctrl   = '0;
    logic [T_W-1:0]   in_target = '0;
    logic [REP_W-1:0] in_repeat = '0;
    logic             in_ready;
    logic [C_W-1:0]   C1;
    logic [T_W-1:0]   T1;
    logic             issue_valid;
    logic             last;
    logic             busy;
`ifdef MICRO_ISSUE_STATS_EN
    logic [STAT_W-1:0] issue_count;
`endif

    microinstruction_issue #(
        .C_W    (C_W),
        .T_W    (T_W),
        .REP_W  (REP_W),
        .T_STEP (T_STEP)
`ifdef MICRO_ISSUE_STATS_EN
        ,
        .STAT_W (STAT_W)
`endif
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ctrl     (in_ctrl),
        .in_target   (in_target),
        .in_repeat   (in_repeat),
        .stall       (stall),
        .C1          (C1),
        .T1          (T1),
        .issue_valid (issue_valid),
        .last        (last),
        .busy        (busy)
`ifdef MICRO_ISSUE_STATS_EN
        ,
        .issue_count (issue_count)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: a burst is expanded up front into a queue of words; one word leaves
    // per unstalled edge, and an op is only taken when the queue is empty.
    typedef struct {
        logic [C_W-1:0] c;
        logic [T_W-1:0] t;
        logic           l;
    } word_t;

    word_t          pend[$];
    logic [C_W-1:0] m_c1;
    logic [T_W-1:0] m_t1;
    logic           m_iv;
    logic           m_last;
    int unsigned    m_cnt;
    int             errors = 0;
    int             checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_c1   = '0;
        m_t1   = '0;
        m_iv   = 1'b0;
        m_last = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_edge();
        word_t w;
        if (stall) return;
        if (pend.size() == 0 && in_valid) begin
            for (int i = 0; i <= int'(in_repeat); i++) begin
                w.c = in_ctrl;
                w.t = in_target + T_W'(i * T_STEP);
                w.l = (i == int'(in_repeat));
                pend.push_back(w);
            end
        end
        if (pend.size() > 0) begin
            w      = pend.pop_front();
            m_c1   = w.c;
            m_t1   = w.t;
            m_iv   = 1'b1;
            m_last = w.l;
            if (m_cnt < (2 ** STAT_W) - 1) m_cnt++;
        end else begin
            m_c1   = '0;
            m_iv   = 1'b0;
            m_last = 1'b0;
        end
    endtask

    task automatic check_outputs(input string where);
        chk({where, ".C1"}, 32'(C1), 32'(m_c1));
        chk({where, ".T1"}, 32'(T1), 32'(m_t1));
        chk({where, ".issue_valid"}, 32'(issue_valid), 32'(m_iv));
        chk({where, ".last"}, 32'(last), 32'(m_last));
`ifdef MICRO_ISSUE_STATS_EN
        chk({where, ".issue_count"}, 32'(issue_count), m_cnt);
`endif
    endtask

    // Inputs are set at posedge+1; handshake outputs checked before the edge, registers after.
    task automatic cycle(input string where);
        #1;
        chk({where, ".in_ready"}, 32'(in_ready), 32'(pend.size() == 0 && !stall));
        chk({where, ".busy"}, 32'(busy), 32'(pend.size() != 0));
        @(posedge clock);
        model_edge();
        #1;
        check_outputs(where);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        stall    = 1'b0;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    logic [T_W-1:0] exp_t [4] = '{7'h7E, 7'h7F, 7'h00, 7'h01};
    int             words;

    initial begin
        // Reset state
        model_reset();
        #2;
        check_outputs("reset");
        chk("reset.busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Test 1: single word then idle bubble
        in_valid = 1'b1; in_ctrl = 6'h15; in_target = 7'h10; in_repeat = '0;
        cycle("t1a");
        chk("t1.C1", 32'(C1), 32'h15);
        chk("t1.T1", 32'(T1), 32'h10);
        chk("t1.last", 32'(last), 32'd1);
        in_valid = 1'b0;
        cycle("t1b");
        chk("t1.bubble_C1", 32'(C1), 32'h0);
        chk("t1.bubble_iv", 32'(issue_valid), 32'd0);
        chk("t1.bubble_T1", 32'(T1), 32'h10);

        // Test 2: burst of 4 with target wrap
        in_valid = 1'b1; in_ctrl = 6'h2A; in_target = 7'h7E; in_repeat = 4'd3;
        cycle("t2a");
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t2.T1", 32'(T1), 32'(exp_t[k]));
            chk("t2.C1", 32'(C1), 32'h2A);
            chk("t2.last", 32'(last), 32'(k == 3));
            chk("t2.busy", 32'(busy), 32'(k != 3));
            chk("t2.in_ready", 32'(in_ready), 32'(k == 3));
            if (k != 3) cycle("t2b");
        end
        cycle("t2c");

        // Test 3: stall for two cycles after word 2
        in_valid = 1'b1;
        words = 0;
        cycle("t3a");
        in_valid = 1'b0;
        words += int'(issue_valid);
        cycle("t3b");
        words += int'(issue_valid);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cycle("t3s");
            chk("t3.frozen_C1", 32'(C1), 32'h2A);
            chk("t3.frozen_T1", 32'(T1), 32'h7F);
            chk("t3.frozen_last", 32'(last), 32'd0);
        end
        stall = 1'b0;
        cycle("t3c");
        words += int'(issue_valid);
        chk("t3.T1_resume0", 32'(T1), 32'h00);
        cycle("t3d");
        words += int'(issue_valid);
        chk("t3.T1_resume1", 32'(T1), 32'h01);
        chk("t3.last_resume1", 32'(last), 32'd1);
        cycle("t3e");
        words += int'(issue_valid);
        chk("t3.words", 32'(words), 32'd4);

        // Test 4: back-to-back single-word ops
        in_valid = 1'b1; in_repeat = '0; in_target = 7'h33;
        for (int k = 1; k <= 5; k++) begin
            in_ctrl = C_W'(k);
            cycle("t4");
            chk("t4.C1", 32'(C1), 32'(k));
            chk("t4.iv", 32'(issue_valid), 32'd1);
        end
        in_valid = 1'b0;
        cycle("t4e");

        // Test 5: async reset mid-burst
        in_valid = 1'b1; in_ctrl = 6'h0C; in_target = 7'h20; in_repeat = 4'd7;
        cycle("t5a");
        in_valid = 1'b0;
        cycle("t5b");
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("t5.C1", 32'(C1), 32'h0);
        chk("t5.T1", 32'(T1), 32'h0);
        chk("t5.iv", 32'(issue_valid), 32'd0);
        chk("t5.busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) cycle("t5idle");

`ifdef MICRO_ISSUE_STATS_EN
        // Test 6: counter saturation; stalls and bubbles do not count
        do_reset();
        in_valid = 1'b1; in_repeat = '0;
        for (int k = 0; k < 20; k++) begin
            in_ctrl = C_W'(k);
            stall   = (k % 5 == 2);
            cycle("t6");
        end
        stall = 1'b0; in_valid = 1'b0;
        cycle("t6e");
        chk("t6.saturated", 32'(issue_count), 32'd15);
`endif

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            stall     = ($urandom_range(0, 99) < 20);
            in_ctrl   = ($urandom_range(0, 7) == 0) ? '0 : C_W'($urandom);
            in_target = T_W'($urandom);
            in_repeat = ($urandom_range(0, 2) == 0) ? '0 : REP_W'($urandom);
            cycle("rnd");
            if (n == 300) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
